// File: rtl/glbl_reg_arb.sv
// Two-master round-robin arbiter in front of a single 8-bit-address register bus.
// One transaction at a time: grant, drive the slave from a latched copy, wait
// for s_ack or a timeout, then return data/ack/err to the owning master.
module glbl_reg_arb #(
    parameter int TO_CYC = 64
) (
    input  logic        mclk,
    input  logic        reset,
    input  logic [1:0]  m_cs,
    input  logic [1:0]  m_wr,
    input  logic [15:0] m_addr,
    input  logic [63:0] m_wdata,
    input  logic [7:0]  m_be,
    output logic [63:0] m_rdata,
    output logic [1:0]  m_ack,
    output logic [1:0]  m_err,
    output logic        s_cs,
    output logic        s_wr,
    output logic [7:0]  s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_be,
    input  logic [31:0] s_rdata,
    input  logic        s_ack,
    output logic [1:0]  grant,
    output logic [7:0]  to_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter value on the last REQ cycle before the transaction is abandoned.
    localparam logic [7:0] TO_LAST = 8'(TO_CYC - 1);

    state_t      state_q;
    logic        lastGrant_q;
    logic [7:0]  timeoutCnt_q;
    logic [1:0]  grant_q;
    logic [1:0]  mAck_q;
    logic [1:0]  mErr_q;
    logic [63:0] mRdata_q;
    logic        sCs_q;
    logic        sWr_q;
    logic [7:0]  sAddr_q;
    logic [31:0] sWdata_q;
    logic [3:0]  sBe_q;
    logic [7:0]  toCnt_q;

    logic        winner_d;
    logic [1:0]  winnerOneHot_d;
    logic        timeout_d;

    // Round-robin pick: on contention the master not served last wins.
    always_comb begin
        winner_d = 1'b0;
        if (m_cs == 2'b11) begin
            winner_d = ~lastGrant_q;
        end else begin
            winner_d = m_cs[1];
        end
        winnerOneHot_d = winner_d ? 2'b10 : 2'b01;
        timeout_d      = (timeoutCnt_q == TO_LAST);
    end

    // Transaction FSM with all bus-facing outputs registered.
    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            lastGrant_q  <= 1'b1;
            timeoutCnt_q <= '0;
            grant_q      <= '0;
            mAck_q       <= '0;
            mErr_q       <= '0;
            mRdata_q     <= '0;
            sCs_q        <= 1'b0;
            sWr_q        <= 1'b0;
            sAddr_q      <= '0;
            sWdata_q     <= '0;
            sBe_q        <= '0;
            toCnt_q      <= '0;
        end else begin
            mAck_q <= '0;
            mErr_q <= '0;
            case (state_q)
                IDLE: begin
                    if (|m_cs) begin
                        state_q      <= REQ;
                        lastGrant_q  <= winner_d;
                        grant_q      <= winnerOneHot_d;
                        timeoutCnt_q <= '0;
                        sCs_q        <= 1'b1;
                        sWr_q        <= winner_d ? m_wr[1]         : m_wr[0];
                        sAddr_q      <= winner_d ? m_addr[15:8]    : m_addr[7:0];
                        sWdata_q     <= winner_d ? m_wdata[63:32]  : m_wdata[31:0];
                        sBe_q        <= winner_d ? m_be[7:4]       : m_be[3:0];
                    end
                end
                REQ: begin
                    if (s_ack) begin
                        state_q <= DONE;
                        sCs_q   <= 1'b0;
                        mAck_q  <= grant_q;
                        if (lastGrant_q) begin
                            mRdata_q[63:32] <= s_rdata;
                        end else begin
                            mRdata_q[31:0] <= s_rdata;
                        end
                    end else if (timeout_d) begin
                        state_q <= DONE;
                        sCs_q   <= 1'b0;
                        mAck_q  <= grant_q;
                        mErr_q  <= grant_q;
                        if (lastGrant_q) begin
                            mRdata_q[63:32] <= '0;
                        end else begin
                            mRdata_q[31:0] <= '0;
                        end
                        if (toCnt_q != 8'hFF) begin
                            toCnt_q <= toCnt_q + 8'd1;
                        end
                    end else begin
                        timeoutCnt_q <= timeoutCnt_q + 8'd1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    grant_q <= '0;
                end
                default: begin
                    state_q <= IDLE;
                    grant_q <= '0;
                    sCs_q   <= 1'b0;
                end
            endcase
        end
    end

    assign m_rdata = mRdata_q;
    assign m_ack   = mAck_q;
    assign m_err   = mErr_q;
    assign s_cs    = sCs_q;
    assign s_wr    = sWr_q;
    assign s_addr  = sAddr_q;
    assign s_wdata = sWdata_q;
    assign s_be    = sBe_q;
    assign grant   = grant_q;
    assign to_cnt  = toCnt_q;

endmodule

// File: doc/glbl_reg_arb.md
GLBL_REG_ARB -- requirements
Module: glbl_reg_arb

Interface
REQ-001 Parameter TO_CYC, default 64, legal range 2..255: cycles of s_cs with no s_ack before the transaction times out.
REQ-002 mclk  in  1  single clock; all state changes on its rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 m_cs  in  2  per-master request; bit i belongs to master i.
REQ-005 m_wr  in  2  per-master write (1) / read (0).
REQ-006 m_addr  in  16  master i uses bits [8i+7:8i].
REQ-007 m_wdata  in  64  master i uses bits [32i+31:32i].
REQ-008 m_be  in  8  master i uses bits [4i+3:4i].
REQ-009 m_rdata  out  64  per-master read data, same slicing as m_wdata.
REQ-010 m_ack  out  2  per-master one-cycle completion pulse.
REQ-011 m_err  out  2  per-master timeout flag, valid only with m_ack.
REQ-012 s_cs, s_wr  out  1 each  slave register-bus strobe and direction.
REQ-013 s_addr  out  8  slave register-bus address.
REQ-014 s_wdata  out  32  slave register-bus write data.
REQ-015 s_be  out  4  slave register-bus byte enables.
REQ-016 s_rdata  in  32  slave read data.
REQ-017 s_ack  in  1  slave one-cycle acknowledge.
REQ-018 grant  out  2  one-hot owner while not IDLE; 0 in IDLE.
REQ-019 to_cnt  out  8  saturating count of timeouts; stops at 255.

Function
REQ-020 FSM states and transitions:
- IDLE -> REQ when any m_cs is high.
- REQ -> DONE on s_ack or on timeout.
- DONE -> IDLE unconditionally after one cycle.
REQ-021 Arbitration in IDLE, round-robin:
- Single request: that master wins.
- Both request: the master not granted last wins.
- last_grant resets to 1, so master 0 wins the first contention.
REQ-022 On grant, the winner's wr/addr/wdata/be are latched; all s_* outputs are driven from the latched copy, never from live master inputs.
REQ-023 s_cs is high exactly while in REQ, so it rises the cycle after the request is seen in IDLE.
REQ-024 On s_ack in REQ:
- s_rdata is registered into the grantee's m_rdata slice.
- m_ack[grantee] pulses high during DONE only.
- m_err stays 0.
REQ-025 The m_rdata slice holds its value until the next completion to the same master; writes also update it with the value s_rdata carries at ack.
REQ-026 Timeout:
- A counter clears on entry to REQ and increments each REQ cycle without s_ack.
- When it reaches TO_CYC-1 without s_ack: go to DONE, pulse m_ack and m_err for the grantee, load m_rdata slice with 0, increment to_cnt (saturating).
REQ-027 s_ack asserted in the same cycle the count reaches TO_CYC-1 is a normal completion, not a timeout.
REQ-028 s_ack outside REQ is ignored.
REQ-029 In DONE, requests are not sampled; each master must drop m_cs the cycle after its m_ack.
REQ-030 A master that drops m_cs before its ack does not abort the slave transaction; the ack and data are still returned.
REQ-031 Minimum latency from m_cs high in IDLE to m_ack, with a slave acking one cycle after s_cs: 3 cycles. Back-to-back throughput: one transaction per 4 cycles.
REQ-032 Only one master is acknowledged per transaction; m_ack never has both bits high.

Reset
REQ-033 While reset is high, all of the following hold asynchronously:
- FSM = IDLE, last_grant = 1, timeout counter = 0.
- s_cs = 0, s_wr = 0, s_addr = 0, s_wdata = 0, s_be = 0.
- m_ack = 0, m_err = 0, m_rdata = 0, grant = 0, to_cnt = 0.
REQ-034 Reset asserted mid-transaction discards it with no ack. The first request after reset release is arbitrated fresh.

Verification
REQ-035 Master 0 writes addr 0x20, wdata 0x1234_5678, be 0xF; slave acks on the 2nd s_cs cycle -> s_addr = 0x20, s_wdata = 0x1234_5678 while s_cs is high; m_ack = 2'b01 exactly 3 cycles after m_cs; m_err = 0.
REQ-036 Master 1 reads addr 0x24, slave returns 0xA55A_0001 -> m_rdata[63:32] = 0xA55A_0001 with m_ack = 2'b10; m_rdata[31:0] unchanged.
REQ-037 Both masters hold m_cs continuously for 4 transactions from reset -> grant sequence 01, 10, 01, 10; each m_ack follows the matching grant.
REQ-038 TO_CYC = 8, slave never acks -> s_cs high for exactly 8 cycles; m_ack and m_err pulse together for the grantee; m_rdata slice = 0; to_cnt increments 0 -> 1.
REQ-039 Reset pulsed while in REQ with s_cs = 1 -> s_cs = 0 and grant = 0 immediately, no m_ack; the next simultaneous request is granted to master 0.
REQ-040 s_ack in the same cycle as the 8th REQ cycle with TO_CYC = 8 -> normal ack, m_err = 0, to_cnt unchanged.
